lane_scroller: RTL and testbench

- Consumes the slow toggling output of the clock divider and turns it into game-lane motion for one row of obstacles (cars/logs) in the frog game.
- Synchronises the slow toggle into the i_Clk domain and detects its rising edges as ticks.
- Prescales the ticks and rotates a per-lane occupancy pattern left or right with wrap-around.
- Answers a single-column occupancy query used by collision logic downstream.

---
 rtl/lane_scroller.sv | 128 ++++++++++++
 tb/tb_lane_scroller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_scroller.sv
// Purpose: rotates one lane of obstacles on each prescaled rising edge of a slow toggle clock.
// Latency: o_Lane shifts on the 3rd i_Clk edge after the slow rise; o_Step follows for one cycle.
// Backpressure: none; i_Enable pauses motion, and i_Load overrides a coincident shift.
module lane_scroller #(
   parameter int                 LANE_W        = 10,
   parameter int                 STEP_DIV      = 1,
   parameter logic [LANE_W-1:0]  RESET_PATTERN = LANE_W'(10'b0000000111)
) (
   input  logic                       i_Clk,
   input  logic                       i_Rst_L,
   input  logic                       i_Slow_Clk,
   input  logic                       i_Enable,
   input  logic                       i_Dir,
   input  logic                       i_Load,
   input  logic [LANE_W-1:0]          i_Pattern,
   input  logic [$clog2(LANE_W)-1:0]  i_Query_Col,
   output logic [LANE_W-1:0]          o_Lane,
   output logic                       o_Step,
   output logic                       o_Occupied
);

   localparam int         QW        = $clog2(LANE_W);
   localparam logic [7:0] PRESC_MAX = 8'(STEP_DIV - 1);

   typedef enum logic [1:0] {
      ARM   = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t              state_q;
   logic [1:0]          arm_cnt_q;
   logic                s1_q, s2_q, s3_q;
   logic [7:0]          presc_q, presc_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic                step_q, step_d;
   logic                tick;
   logic                load_ok;
   logic                wrap;

   // Two-flop synchroniser for the slow toggle plus one history flop for edge detection.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= i_Slow_Clk;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // Mode FSM: ARM lets the sync chain fill with real samples before any edge counts.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q   <= ARM;
         arm_cnt_q <= 2'd0;
      end else begin
         case (state_q)
            ARM: begin
               if (arm_cnt_q == 2'd2) begin
                  state_q <= i_Enable ? RUN : PAUSE;
               end else begin
                  arm_cnt_q <= arm_cnt_q + 2'd1;
               end
            end
            RUN: begin
               if (!i_Enable) begin
                  state_q <= PAUSE;
               end
            end
            PAUSE: begin
               if (i_Enable) begin
                  state_q <= RUN;
               end
            end
            default: state_q <= ARM;
         endcase
      end
   end

   assign tick    = s2_q & ~s3_q & (state_q == RUN);
   assign load_ok = i_Load & (state_q != ARM);
   assign wrap    = (presc_q == PRESC_MAX);

   // Next lane/prescaler: a load beats a shift; column 0 is the leftmost cell.
   always_comb begin
      lane_d  = lane_q;
      presc_d = presc_q;
      step_d  = 1'b0;
      if (load_ok) begin
         lane_d  = i_Pattern;
         presc_d = 8'd0;
      end else if (tick) begin
         if (wrap) begin
            presc_d = 8'd0;
            step_d  = 1'b1;
            if (i_Dir) begin
               lane_d = {lane_q[LANE_W-2:0], lane_q[LANE_W-1]};
            end else begin
               lane_d = {lane_q[0], lane_q[LANE_W-1:1]};
            end
         end else begin
            presc_d = presc_q + 8'd1;
         end
      end
   end

   // Lane, prescaler and step pulse registers.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         lane_q  <= RESET_PATTERN;
         presc_q <= 8'd0;
         step_q  <= 1'b0;
      end else begin
         lane_q  <= lane_d;
         presc_q <= presc_d;
         step_q  <= step_d;
      end
   end

   assign o_Lane     = lane_q;
   assign o_Step     = step_q;
   // Column indices past the lane end read as empty.
   assign o_Occupied = ({1'b0, i_Query_Col} < (QW+1)'(LANE_W)) ? lane_q[i_Query_Col] : 1'b0;

endmodule

// File: tb/tb_lane_scroller.sv
// Bench for lane_scroller: directed scenarios with literal expectations, then random traffic.
// A per-edge behavioural model computes lane/step/occupancy from sampled input history.
// Outputs are compared every cycle, one time unit after the falling clock edge.
module tb_lane_scroller;
   localparam int W   = 8;
   localparam int DIV = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       slow, en, dir, load;
   logic [7:0] pat;
   logic [2:0] qcol;
   logic [7:0] lane;
   logic       step, occ;

   int checks = 0;
   int errors = 0;
   int step_cnt = 0;

   always #5 clk = ~clk;

   lane_scroller #(
      .LANE_W       (W),
      .STEP_DIV     (DIV),
      .RESET_PATTERN(8'h03)
   ) dut (
      .i_Clk      (clk),
      .i_Rst_L    (rst_n),
      .i_Slow_Clk (slow),
      .i_Enable   (en),
      .i_Dir      (dir),
      .i_Load     (load),
      .i_Pattern  (pat),
      .i_Query_Col(qcol),
      .o_Lane     (lane),
      .o_Step     (step),
      .o_Occupied (occ)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Edge k (k=1 is the first rising clock edge after reset release) samples
   // slow(k) and en(k). A slow rise first sampled at edge k is acted on at edge k+2,
   // provided the lane is running; the lane runs after edge k when k>=3 and en(k)=1.
   logic [7:0] m_lane;
   logic [7:0] m_nxt;
   logic       m_step;
   int         m_presc;
   int         m_t;
   bit         m_samp[$];
   bit         m_en[$];
   bit         m_active, m_running, m_rise;

   function automatic bit samp_at(int k);
      return (k < 1) ? 1'b0 : m_samp[k-1];
   endfunction

   function automatic bit en_at(int k);
      return (k < 1) ? 1'b0 : m_en[k-1];
   endfunction

   // Model update on each rising edge; reset returns it to the power-up picture.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_lane  = 8'h03;
         m_step  = 1'b0;
         m_presc = 0;
         m_t     = 0;
         m_samp.delete();
         m_en.delete();
      end else begin
         m_t++;
         m_active  = (m_t - 1) >= 3;
         m_running = m_active && en_at(m_t - 1);
         m_rise    = samp_at(m_t - 2) && !samp_at(m_t - 3);
         m_step    = 1'b0;
         if (m_active && load) begin
            m_lane  = pat;
            m_presc = 0;
         end else if (m_running && m_rise) begin
            if (m_presc == DIV - 1) begin
               for (int c = 0; c < W; c++)
                  m_nxt[c] = dir ? m_lane[(c + W - 1) % W] : m_lane[(c + 1) % W];
               m_lane  = m_nxt;
               m_presc = 0;
               m_step  = 1'b1;
            end else begin
               m_presc++;
            end
         end
         m_samp.push_back(slow);
         m_en.push_back(en);
      end
   end

   // Per-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      #1;
      if (rst_n === 1'b1) begin
         check("lane", lane, m_lane);
         check("step", step, m_step);
         check("occupied", occ, m_lane[qcol]);
         check("popcount_kept", $countones(lane), $countones(m_lane));
         if (step === 1'b1) step_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic periods(input int n);
      repeat (n) begin
         slow = 1'b1;
         cyc(10);
         slow = 1'b0;
         cyc(10);
      end
   endtask

   bit exp_occ [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
   int hp_cnt;

   initial begin
      rst_n = 1'b0; slow = 1'b1; en = 1'b1; dir = 1'b0;
      load = 1'b0; pat = 8'h00; qcol = 3'd0;

      // Reset with the slow clock already high.
      cyc(3);
      #2;
      check("reset_lane", lane, 8'h03);
      check("reset_step", step, 1'b0);
      rst_n = 1'b1;
      cyc(2);
      #2 check("arm_no_step", step, 1'b0);
      cyc(10);
      #2 check("no_false_edge", lane, 8'h03);
      slow = 1'b0;
      cyc(10);

      // Left shift after two rises; step exactly on edge 3 after the 2nd rise.
      step_cnt = 0;
      periods(1);
      slow = 1'b1;
      cyc(2);
      #2 check("pre_shift_lane", lane, 8'h03);
      cyc(1);
      #2;
      check("left_wrap_lane", lane, 8'h81);
      check("left_step_edge3", step, 1'b1);
      cyc(7);
      slow = 1'b0;
      cyc(10);
      check("one_step_pulse", step_cnt, 1);

      // Right shifts.
      dir = 1'b1;
      periods(2);
      #2 check("right_back", lane, 8'h03);
      periods(4);
      #2;
      check("right_two_more", lane, 8'h0C);
      check("popcount_two", $countones(lane), 2);

      // Pause holds the prescaler.
      periods(1);
      en = 1'b0;
      periods(3);
      #2 check("paused_lane", lane, 8'h0C);
      en = 1'b1;
      cyc(2);
      periods(1);
      #2 check("resume_shift", lane, 8'h18);

      // Load coinciding with a shift tick.
      periods(1);
      slow = 1'b1;
      cyc(2);
      load = 1'b1;
      pat  = 8'hF0;
      cyc(1);
      load = 1'b0;
      #2;
      check("load_wins_lane", lane, 8'hF0);
      check("load_wins_step", step, 1'b0);
      cyc(7);
      slow = 1'b0;
      cyc(10);

      // Column query sweep.
      for (int q = 0; q < 8; q++) begin
         qcol = 3'(q);
         #2 check($sformatf("query_col%0d", q), occ, exp_occ[q]);
         cyc(1);
      end

      periods(1);
      #2 check("load_cleared_presc", lane, 8'hF0);
      periods(1);
      #2 check("shift_after_load", lane, 8'hE1);

      // Reset right after a shift lands.
      periods(1);
      slow = 1'b1;
      cyc(2);
      @(posedge clk);
      #1;
      check("pre_reset_step", step, 1'b1);
      check("pre_reset_lane", lane, 8'hC3);
      #1 rst_n = 1'b0;
      #1;
      check("async_reset_lane", lane, 8'h03);
      check("async_reset_step", step, 1'b0);
      cyc(2);
      slow = 1'b0;
      #2 rst_n = 1'b1;

      // Random traffic with occasional resets (loads may land in ARM).
      hp_cnt = 3;
      for (int n = 0; n < 4000; n++) begin
         cyc(1);
         if (hp_cnt == 0) begin
            slow   = ~slow;
            hp_cnt = $urandom_range(1, 12);
         end else begin
            hp_cnt--;
         end
         if ($urandom_range(0, 29) == 0) en = ~en;
         if ($urandom_range(0, 9) == 0) dir = ~dir;
         load = ($urandom_range(0, 39) == 0);
         pat  = 8'($urandom);
         qcol = 3'($urandom);
         if (n % 1000 == 999) begin
            #2 rst_n = 1'b0;
            cyc(2);
            #2 rst_n = 1'b1;
         end
      end
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
